tx_frame_ctrl: RTL and testbench

TX_FRAME_CTRL -- requirements
Module: tx_frame_ctrl

---
 rtl/tx_frame_ctrl_if.sv | 31 +++
 rtl/tx_frame_ctrl.sv | 165 ++++++++++++++++
 tb/tb_tx_frame_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/tx_frame_ctrl_if.sv
// Frame-controller bus: config/start requests from the MAC side, slot timing and
// shadowed config back out. Single clock domain; no handshake, all pulses are one cycle.
interface tx_frame_ctrl_if;
    logic [2:0] index_M;
    logic [3:0] index_SS;
    logic [2:0] index_BW;
    logic       cfg_upd;
    logic       start;
    logic [7:0] n_data;
    logic       busy;
    logic       osof;
    logic       sym_sop;
    logic [1:0] sym_type;
    logic [7:0] sym_idx;
    logic       data_en;
    logic [2:0] oindex_M;
    logic [3:0] oindex_SS;
    logic [2:0] oindex_BW;

    modport master (
        output index_M, index_SS, index_BW, cfg_upd, start, n_data,
        input  busy, osof, sym_sop, sym_type, sym_idx, data_en,
               oindex_M, oindex_SS, oindex_BW
    );

    modport slave (
        input  index_M, index_SS, index_BW, cfg_upd, start, n_data,
        output busy, osof, sym_sop, sym_type, sym_idx, data_en,
               oindex_M, oindex_SS, oindex_BW
    );
endinterface

// File: rtl/tx_frame_ctrl.sv
// OFDM TX frame sequencer: preamble/header/data slots then a gap, with shadowed config.
// Outputs registered, one cycle after the deciding input; start while busy queues one frame.
// No backpressure: slots free-run once a frame starts, a single extra start is held pending.
module tx_frame_ctrl #(
    parameter int pSYM_LEN = 1056,
    parameter int pN_PRE   = 2,
    parameter int pGAP     = 64
) (
    input  logic           clk,
    input  logic           rst,
    tx_frame_ctrl_if.slave bus
);
    localparam int CW = $clog2((pSYM_LEN > pGAP) ? pSYM_LEN : pGAP);
    localparam logic [CW-1:0] SYM_LAST = CW'(pSYM_LEN - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(pGAP - 1);
    localparam logic [7:0]    PRE_LAST = 8'(pN_PRE - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_HDR, ST_DATA, ST_GAP} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [7:0]      r_idx, w_idx_nxt;
    logic            r_start_pend;
    logic [7:0]      r_n_lat;
    logic [2:0]      r_pend_M, r_act_M;
    logic [3:0]      r_pend_SS, r_act_SS;
    logic [2:0]      r_pend_BW, r_act_BW;
    logic            r_busy, r_osof, r_sop, r_data_en;
    logic [1:0]      r_type, w_type_nxt;
    logic            w_pre_entry, w_in_slot, w_go;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_go        = bus.start || r_start_pend;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (w_go) w_state_nxt = ST_PRE;
            end
            ST_PRE: begin
                if (r_cnt == SYM_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_idx == PRE_LAST) begin
                        w_state_nxt = ST_HDR;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + 8'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_HDR: begin
                if (r_cnt == SYM_LAST) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = (r_n_lat != 8'd0) ? ST_DATA : ST_GAP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (r_cnt == SYM_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_idx == r_n_lat - 8'd1) begin
                        w_state_nxt = ST_GAP;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + 8'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = w_go ? ST_PRE : ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase

        w_pre_entry = (w_state_nxt == ST_PRE) && (r_state != ST_PRE);
        w_in_slot   = (w_state_nxt == ST_PRE) || (w_state_nxt == ST_HDR) ||
                      (w_state_nxt == ST_DATA);
        case (w_state_nxt)
            ST_PRE:  w_type_nxt = 2'd1;
            ST_HDR:  w_type_nxt = 2'd2;
            ST_DATA: w_type_nxt = 2'd3;
            default: w_type_nxt = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_start_pend <= 1'b0;
            r_n_lat      <= '0;
            r_pend_M     <= '0;
            r_pend_SS    <= '0;
            r_pend_BW    <= '0;
            r_act_M      <= '0;
            r_act_SS     <= '0;
            r_act_BW     <= '0;
            r_busy       <= 1'b0;
            r_osof       <= 1'b0;
            r_sop        <= 1'b0;
            r_type       <= '0;
            r_data_en    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;

            // One-deep request queue; a start landing on the PRE entry edge is consumed by it.
            if (w_pre_entry)
                r_start_pend <= 1'b0;
            else if (bus.start && (r_state != ST_IDLE))
                r_start_pend <= 1'b1;

            if (bus.cfg_upd) begin
                r_pend_M  <= (bus.index_M > 3'd5) ? 3'd5 : bus.index_M;
                r_pend_SS <= bus.index_SS;
                r_pend_BW <= bus.index_BW;
            end

            // Pending values sampled before this edge's cfg_upd, so a coincident update waits a frame.
            if (w_pre_entry) begin
                r_n_lat  <= bus.n_data;
                r_act_M  <= r_pend_M;
                r_act_SS <= r_pend_SS;
                r_act_BW <= r_pend_BW;
            end

            r_busy    <= (w_state_nxt != ST_IDLE);
            r_osof    <= w_pre_entry;
            r_sop     <= w_in_slot && (w_cnt_nxt == '0);
            r_type    <= w_type_nxt;
            r_data_en <= (w_state_nxt == ST_DATA);
        end
    end

    assign bus.busy      = r_busy;
    assign bus.osof      = r_osof;
    assign bus.sym_sop   = r_sop;
    assign bus.sym_type  = r_type;
    assign bus.sym_idx   = r_idx;
    assign bus.data_en   = r_data_en;
    assign bus.oindex_M  = r_act_M;
    assign bus.oindex_SS = r_act_SS;
    assign bus.oindex_BW = r_act_BW;
endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Directed bench for tx_frame_ctrl with short slots (8 cycles, 2 preambles, 4-cycle gap).
// Each frame cycle is compared against a slot-position model of the output vector.
module tb_tx_frame_ctrl;
    localparam int SL = 8;
    localparam int NP = 2;
    localparam int GP = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   fid;

    tx_frame_ctrl_if ifc ();

    tx_frame_ctrl #(.pSYM_LEN(SL), .pN_PRE(NP), .pGAP(GP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] obs_vec();
        return {ifc.busy, ifc.osof, ifc.sym_sop, ifc.sym_type, ifc.data_en,
                ifc.sym_idx, ifc.oindex_M, ifc.oindex_SS, ifc.oindex_BW};
    endfunction

    task automatic chk(input string tag, input logic [23:0] o, input logic [23:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic do_cfg(input logic [2:0] m, input logic [3:0] ss, input logic [2:0] bw);
        ifc.index_M  = m;
        ifc.index_SS = ss;
        ifc.index_BW = bw;
        ifc.cfg_upd  = 1'b1;
        tick();
        ifc.cfg_upd  = 1'b0;
    endtask

    task automatic pulse_start(input int n, input bit cfg, input logic [2:0] m);
        ifc.n_data = 8'(n);
        ifc.start  = 1'b1;
        ifc.cfg_upd = cfg;
        if (cfg) ifc.index_M = m;
        tick();
        ifc.start   = 1'b0;
        ifc.cfg_upd = 1'b0;
    endtask

    // Called on the first PRE cycle; returns on the cycle after the gap.
    task automatic watch_frame(input int n, input logic [2:0] m, input int sk1, input int sk2,
                               input int ck, input logic [2:0] cm, input bit exp_next);
        int dat_end;
        int len;
        logic [1:0] typ;
        logic [7:0] idx;
        logic sop;
        dat_end = (NP + 1 + n) * SL;
        len     = dat_end + GP;
        fid++;
        for (int k = 0; k < len; k++) begin
            if (k < NP * SL) begin
                typ = 2'd1; idx = 8'(k / SL);
            end else if (k < (NP + 1) * SL) begin
                typ = 2'd2; idx = 8'd0;
            end else if (k < dat_end) begin
                typ = 2'd3; idx = 8'((k - (NP + 1) * SL) / SL);
            end else begin
                typ = 2'd0; idx = 8'd0;
            end
            sop = (k < dat_end) && (k % SL == 0);
            chk($sformatf("frame%0d_k%0d", fid, k), obs_vec(),
                {1'b1, (k == 0), sop, typ, (typ == 2'd3), idx, m, 4'd5, 3'd2});
            ifc.start = (k == sk1) || (k == sk2);
            if (k == ck) begin
                ifc.cfg_upd = 1'b1;
                ifc.index_M = cm;
            end else begin
                ifc.cfg_upd = 1'b0;
            end
            tick();
        end
        ifc.start   = 1'b0;
        ifc.cfg_upd = 1'b0;
        chk($sformatf("frame%0d_after_busy_osof", fid), {22'd0, ifc.busy, ifc.osof},
            {22'd0, exp_next, exp_next});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        fid      = 0;
        rst = 1'b1;
        ifc.index_M  = 3'd0;
        ifc.index_SS = 4'd5;
        ifc.index_BW = 3'd2;
        ifc.cfg_upd  = 1'b0;
        ifc.start    = 1'b0;
        ifc.n_data   = 8'd0;
        #2 rst = 1'b0;
        tick();
        tick();
        chk("reset_outputs", obs_vec(), 24'd0);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("no_autostart", obs_vec(), 24'd0);

        // Single frame, n_data=3
        do_cfg(3'd3, 4'd5, 3'd2);
        tick();
        pulse_start(3, 1'b0, 3'd0);
        watch_frame(3, 3'd3, -1, -1, -1, 3'd0, 1'b0);
        tick();

        // Empty frame, header then gap
        pulse_start(0, 1'b0, 3'd0);
        watch_frame(0, 3'd3, -1, -1, -1, 3'd0, 1'b0);
        tick();

        // Back-to-back via start in DATA, third start dropped, mid-frame cfg shadowed
        pulse_start(2, 1'b0, 3'd0);
        watch_frame(2, 3'd3, 26, 33, 10, 3'd1, 1'b1);
        watch_frame(2, 3'd1, -1, -1, -1, 3'd0, 1'b0);
        tick();

        // Clamp M=7 -> 5, start on the last gap cycle chains a frame
        do_cfg(3'd7, 4'd5, 3'd2);
        pulse_start(1, 1'b0, 3'd0);
        watch_frame(1, 3'd5, (NP + 2) * SL + GP - 1, -1, -1, 3'd0, 1'b1);
        watch_frame(1, 3'd5, -1, -1, -1, 3'd0, 1'b0);
        tick();

        // cfg_upd on the PRE-entry edge applies only to the following frame
        pulse_start(0, 1'b1, 3'd4);
        watch_frame(0, 3'd5, -1, -1, -1, 3'd0, 1'b0);
        pulse_start(0, 1'b0, 3'd0);
        watch_frame(0, 3'd4, -1, -1, -1, 3'd0, 1'b0);
        tick();

        // Reset in DATA with a start pending
        pulse_start(3, 1'b0, 3'd0);
        for (int k = 0; k < 30; k++) begin
            ifc.start = (k == 28);
            tick();
        end
        ifc.start = 1'b0;
        chk("pre_reset_data_en", {23'd0, ifc.data_en}, 24'd1);
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", obs_vec(), 24'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            chk($sformatf("post_reset_idle_%0d", i), obs_vec(), 24'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
